// File: rtl/score_keeper_if.sv
// +------------------------------------------------------------------+
// | score_keeper_if : playfield <-> score keeper event/status bundle |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface score_keeper_if;
  logic       game_start;
  logic       game_over;
  logic       clear_valid;
  logic [2:0] line_count;
  logic       clear_ready;
  logic [7:0] score;
  logic [3:0] level;
  logic [7:0] high_score;
  logic       playing;

  modport master (
    output game_start, game_over, clear_valid, line_count,
    input  clear_ready, score, level, high_score, playing
  );

  modport slave (
    input  game_start, game_over, clear_valid, line_count,
    output clear_ready, score, level, high_score, playing
  );
endinterface

`default_nettype wire

// File: rtl/score_keeper.sv
// +------------------------------------------------------------------+
// | score_keeper : saturating score/lines/level keeper for the game  |
// | Optional high-score register built when HIGH_SCORE_EN is defined |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module score_keeper #(
  parameter int SCORE_MAX       = 99,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 9
) (
  input  logic          clk,
  input  logic          rst,
  score_keeper_if.slave bus_io
);

  localparam logic [7:0] c_score_max       = 8'(SCORE_MAX);
  localparam logic [7:0] c_lines_per_level = 8'(LINES_PER_LEVEL);
  localparam logic [7:0] c_max_level       = 8'(MAX_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_ADD  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] score_q, score_d;
  logic [7:0] lines_q, lines_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] level_q, level_d;

  logic       w_restart;
  logic [3:0] w_points;
  logic [8:0] w_lines_sum;
  logic [7:0] w_score_inc;
  logic [7:0] w_level_raw;

  always_comb begin
    w_points = 4'd0;
    case (bus_io.line_count)
      3'd1:    w_points = 4'd1;
      3'd2:    w_points = 4'd3;
      3'd3:    w_points = 4'd5;
      3'd4:    w_points = 4'd8;
      default: w_points = 4'd0;
    endcase
  end

  assign w_lines_sum = {1'b0, lines_q} + {6'd0, bus_io.line_count};
  assign w_score_inc = (score_q >= c_score_max) ? c_score_max : score_q + 8'd1;
  assign w_level_raw = lines_q / c_lines_per_level;

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lines_d   = lines_q;
    pending_d = pending_q;
    w_restart = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus_io.game_start) begin
          w_restart = 1'b1;
        end
      end
      ST_PLAY: begin
        // game_over outranks both a restart and a coincident transfer
        if (bus_io.game_over) begin
          state_d   = ST_OVER;
          pending_d = 4'd0;
        end else if (bus_io.game_start) begin
          w_restart = 1'b1;
        end else if (bus_io.clear_valid && (w_points != 4'd0)) begin
          pending_d = w_points;
          lines_d   = w_lines_sum[8] ? 8'hFF : w_lines_sum[7:0];
          state_d   = ST_ADD;
        end
      end
      ST_ADD: begin
        if (bus_io.game_over) begin
          state_d   = ST_OVER;
          pending_d = 4'd0;
        end else if (bus_io.game_start) begin
          w_restart = 1'b1;
        end else begin
          score_d   = w_score_inc;
          pending_d = pending_q - 4'd1;
          if ((pending_q <= 4'd1) || (w_score_inc == c_score_max)) begin
            state_d   = ST_PLAY;
            pending_d = 4'd0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_restart) begin
      state_d   = ST_PLAY;
      score_d   = 8'd0;
      lines_d   = 8'd0;
      pending_d = 4'd0;
    end

    if (w_restart) begin
      level_d = 4'd0;
    end else if (w_level_raw > c_max_level) begin
      level_d = c_max_level[3:0];
    end else begin
      level_d = w_level_raw[3:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      score_q   <= 8'd0;
      lines_q   <= 8'd0;
      pending_q <= 4'd0;
      level_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      lines_q   <= lines_d;
      pending_q <= pending_d;
      level_q   <= level_d;
    end
  end

  assign bus_io.clear_ready = (state_q == ST_PLAY);
  assign bus_io.playing     = (state_q == ST_PLAY) || (state_q == ST_ADD);
  assign bus_io.score       = score_q;
  assign bus_io.level       = level_q;

`ifdef HIGH_SCORE_EN
  logic [7:0] high_q;
  logic       w_enter_over;

  assign w_enter_over = bus_io.game_over &&
                        ((state_q == ST_PLAY) || (state_q == ST_ADD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_q <= 8'd0;
    end else if (w_enter_over && (score_q > high_q)) begin
      high_q <= score_q;
    end
  end

  assign bus_io.high_score = high_q;
`else
  assign bus_io.high_score = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// +------------------------------------------------------------------+
// | tb_score_keeper : directed + random bench with game-rule model   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_score_keeper;
  logic clk = 1'b0;
  logic rst = 1'b1;

  score_keeper_if sk();

  score_keeper dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (sk)
  );

  always #5 clk = ~clk;

`ifdef HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Game model: score, total lines and best finished score
  int m_score = 0;
  int m_lines = 0;
  int m_high  = 0;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int pts_of(int n);
    case (n)
      1: return 1;
      2: return 3;
      3: return 5;
      4: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int lvl_of(int l);
    return imin(l / 10, 9);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_score"}, 32'(sk.score), 0);
    check({tag, "_level"}, 32'(sk.level), 0);
    check({tag, "_high"},  32'(sk.high_score), 0);
    check({tag, "_ready"}, 32'(sk.clear_ready), 0);
    check({tag, "_play"},  32'(sk.playing), 0);
  endtask

  task automatic start_game();
    sk.game_start = 1'b1;
    tick();
    sk.game_start = 1'b0;
    m_score = 0;
    m_lines = 0;
    check("start_score", 32'(sk.score), 0);
    check("start_level", 32'(sk.level), 0);
    check("start_ready", 32'(sk.clear_ready), 1);
    check("start_play",  32'(sk.playing), 1);
  endtask

  task automatic end_game();
    sk.game_over = 1'b1;
    tick();
    sk.game_over = 1'b0;
    if (HS_EN && (m_score > m_high)) m_high = m_score;
    check("over_play",  32'(sk.playing), 0);
    check("over_ready", 32'(sk.clear_ready), 0);
    check("over_score", 32'(sk.score), 32'(m_score));
    check("over_high",  32'(sk.high_score), 32'(m_high));
  endtask

  task automatic send_event(input int n);
    int p;
    int exp_cyc;
    int cnt;
    int old_lvl;
    p       = pts_of(n);
    old_lvl = lvl_of(m_lines);
    check("pre_ready", 32'(sk.clear_ready), 1);
    sk.clear_valid = 1'b1;
    sk.line_count  = 3'(n);
    tick();
    sk.clear_valid = 1'b0;
    sk.line_count  = 3'd0;
    check("xfer_level", 32'(sk.level), 32'(old_lvl));
    if (p == 0)             exp_cyc = 0;
    else if (m_score >= 99) exp_cyc = 1;
    else                    exp_cyc = imin(p, 99 - m_score);
    cnt = 0;
    while ((sk.clear_ready !== 1'b1) && (cnt < 20)) begin
      tick();
      cnt++;
    end
    if (p > 0) begin
      m_score = imin(m_score + p, 99);
      m_lines = imin(m_lines + n, 255);
    end
    check("busy_cycles", 32'(cnt), 32'(exp_cyc));
    check("score", 32'(sk.score), 32'(m_score));
    check("level", 32'(sk.level), 32'(lvl_of(m_lines)));
  endtask

  initial begin
    sk.game_start  = 1'b0;
    sk.game_over   = 1'b0;
    sk.clear_valid = 1'b0;
    sk.line_count  = 3'd0;

    repeat (2) tick();
    check_reset_outs("rst");
    rst = 1'b0;
    tick();

    // IDLE ignores events and game_over
    sk.clear_valid = 1'b1;
    sk.line_count  = 3'd4;
    sk.game_over   = 1'b1;
    repeat (2) tick();
    sk.clear_valid = 1'b0;
    sk.game_over   = 1'b0;
    check_reset_outs("idle");

    // T1 / T2
    start_game();
    send_event(1);
    start_game();
    send_event(4);

    // T3: reach 95 then saturate
    start_game();
    repeat (11) send_event(4);
    send_event(3);
    send_event(1);
    send_event(1);
    check("t3_95", 32'(sk.score), 95);
    send_event(4);
    send_event(1);
    check("t3_sat", 32'(sk.score), 99);

    // T4: level step after 10 lines, cap at 9
    start_game();
    repeat (10) send_event(1);
    check("t4_lvl1", 32'(sk.level), 1);
    repeat (23) send_event(4);
    check("t4_lvl9", 32'(sk.level), 9);

    // T5: game_over 3 cycles into an 8-point award from 10
    start_game();
    send_event(4);
    send_event(1);
    send_event(1);
    sk.clear_valid = 1'b1;
    sk.line_count  = 3'd4;
    tick();
    sk.clear_valid = 1'b0;
    sk.line_count  = 3'd0;
    repeat (3) tick();
    check("t5_mid", 32'(sk.score), 13);
    m_score = 13;
    end_game();
    repeat (3) tick();
    check("t5_frozen", 32'(sk.score), 13);
    check("t5_high", 32'(sk.high_score), HS_EN ? 13 : 0);
    start_game();
    send_event(3);
    end_game();
    check("t5_high2", 32'(sk.high_score), HS_EN ? 13 : 0);

    // game_over together with a transfer discards the transfer
    start_game();
    send_event(2);
    sk.clear_valid = 1'b1;
    sk.line_count  = 3'd4;
    sk.game_over   = 1'b1;
    tick();
    sk.clear_valid = 1'b0;
    sk.line_count  = 3'd0;
    sk.game_over   = 1'b0;
    if (HS_EN && (m_score > m_high)) m_high = m_score;
    check("ovx_play", 32'(sk.playing), 0);
    tick();
    check("ovx_score", 32'(sk.score), 3);
    check("ovx_level", 32'(sk.level), 0);
    check("ovx_high", 32'(sk.high_score), 32'(m_high));

    // both pulses together: game_over wins
    start_game();
    send_event(1);
    sk.game_start = 1'b1;
    sk.game_over  = 1'b1;
    tick();
    sk.game_start = 1'b0;
    sk.game_over  = 1'b0;
    check("both_play",  32'(sk.playing), 0);
    check("both_score", 32'(sk.score), 1);

    // restart while an award is in progress
    start_game();
    sk.clear_valid = 1'b1;
    sk.line_count  = 3'd4;
    tick();
    sk.clear_valid = 1'b0;
    sk.line_count  = 3'd0;
    repeat (2) tick();
    check("rs_mid", 32'(sk.score), 2);
    start_game();

    // T6: async reset mid-award
    sk.clear_valid = 1'b1;
    sk.line_count  = 3'd4;
    tick();
    sk.clear_valid = 1'b0;
    sk.line_count  = 3'd0;
    tick();
    #2 rst = 1'b1;
    #1;
    check_reset_outs("arst");
    rst = 1'b0;
    m_high = 0;
    tick();
    check_reset_outs("post_rst");
    start_game();
    send_event(0);
    send_event(7);
    check("t6_nochg", 32'(sk.score), 0);

    // Random play against the model
    for (int i = 0; i < 80; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        end_game();
        start_game();
      end else if (r == 1) begin
        start_game();
      end else begin
        send_event(int'($urandom_range(0, 7)));
      end
    end
    end_game();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
